// File: rtl/pea_loader_if.sv
// Host-side bundle for the PEA loader: command channel, write-data stream and readback stream.
interface pea_loader_if #(
    parameter int CFG_AW = 12,
    parameter int CFG_DW = 96,
    parameter int DW     = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [CFG_AW-1:0] cmd_base;
    logic [15:0]       cmd_len;
    logic [15:0]       cmd_arg;
    logic              s_valid;
    logic              s_ready;
    logic [CFG_DW-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DW-1:0]     m_data;

    modport master (
        output cmd_valid, cmd_op, cmd_base, cmd_len, cmd_arg, s_valid, s_data, m_ready,
        input  cmd_ready, s_ready, m_valid, m_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_base, cmd_len, cmd_arg, s_valid, s_data, m_ready,
        output cmd_ready, s_ready, m_valid, m_data
    );
endinterface

// File: rtl/pea_loader.sv
// PEA loader: streams config/LDM words into the PE array, launches runs and reads LDM words back,
// one command at a time, with every output driven from a register.
module pea_loader #(
    parameter int CFG_AW = 12,
    parameter int CFG_DW = 96,
    parameter int LDM_AW = 8,
    parameter int DW     = 32
) (
    input  logic              CLK,
    input  logic              RST,
    pea_loader_if.slave       bus,
    output logic              busy,
    output logic [7:0]        start_out,
    output logic [CFG_AW-1:0] CFG_addra_out,
    output logic [CFG_DW-1:0] CFG_dina_out,
    output logic              CFG_ena_out,
    output logic              CFG_wea_out,
    output logic [7:0]        CFG_incr_out,
    output logic [LDM_AW-1:0] LDM_addra_out,
    output logic [DW-1:0]     LDM_dina_out,
    output logic              LDM_ena_out,
    output logic              LDM_wea_out,
    input  logic [DW-1:0]     LDM_douta_in,
    input  logic              LDM_douta_valid_in
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_CFG  = 3'd1,
        WR_LDM  = 3'd2,
        RUN     = 3'd3,
        RD_REQ  = 3'd4,
        RD_WAIT = 3'd5,
        RD_OUT  = 3'd6
    } state_t;

    state_t            state_q;
    logic [CFG_AW-1:0] base_q;
    logic [15:0]       idx_q;
    logic [16:0]       cnt_q;
    logic              cmd_ready_q;
    logic              s_ready_q;
    logic              m_valid_q;
    logic [DW-1:0]     m_data_q;
    logic              busy_q;
    logic [7:0]        start_q;
    logic [7:0]        incr_q;
    logic [CFG_AW-1:0] cfg_addr_q;
    logic [CFG_DW-1:0] cfg_din_q;
    logic              cfg_we_q;
    logic [LDM_AW-1:0] ldm_addr_q;
    logic [DW-1:0]     ldm_din_q;
    logic              ldm_ena_q;
    logic              ldm_wea_q;

    logic              beat_s;
    logic              last_s;
    logic [15:0]       idx_inc_s;
    logic [CFG_AW-1:0] cfg_addr_d;
    logic [LDM_AW-1:0] ldm_addr_d;
    logic [LDM_AW-1:0] ldm_addr_nx_d;

    // cnt counts down the remaining beats/words/cycles; zero marks the final one.
    assign beat_s        = bus.s_valid & s_ready_q;
    assign last_s        = (cnt_q == 17'd0);
    assign idx_inc_s     = idx_q + 16'd1;
    assign cfg_addr_d    = base_q + idx_q[CFG_AW-1:0];
    assign ldm_addr_d    = base_q[LDM_AW-1:0] + idx_q[LDM_AW-1:0];
    assign ldm_addr_nx_d = base_q[LDM_AW-1:0] + idx_inc_s[LDM_AW-1:0];

    // Command sequencer with all outputs registered alongside the state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            base_q      <= '0;
            idx_q       <= 16'd0;
            cnt_q       <= 17'd0;
            cmd_ready_q <= 1'b0;
            s_ready_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            busy_q      <= 1'b0;
            start_q     <= 8'd0;
            incr_q      <= 8'd0;
            cfg_addr_q  <= '0;
            cfg_din_q   <= '0;
            cfg_we_q    <= 1'b0;
            ldm_addr_q  <= '0;
            ldm_din_q   <= '0;
            ldm_ena_q   <= 1'b0;
            ldm_wea_q   <= 1'b0;
        end else begin
            cfg_we_q  <= 1'b0;
            ldm_ena_q <= 1'b0;
            ldm_wea_q <= 1'b0;
            start_q   <= 8'd0;
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (bus.cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        base_q      <= bus.cmd_base;
                        idx_q       <= 16'd0;
                        cnt_q       <= {1'b0, bus.cmd_len};
                        case (bus.cmd_op)
                            2'b00: begin
                                state_q   <= WR_CFG;
                                s_ready_q <= 1'b1;
                            end
                            2'b01: begin
                                state_q   <= WR_LDM;
                                s_ready_q <= 1'b1;
                            end
                            2'b10: begin
                                // Pulse cycle plus N+1 wait cycles.
                                state_q <= RUN;
                                start_q <= bus.cmd_arg[7:0];
                                incr_q  <= bus.cmd_arg[15:8];
                                cnt_q   <= {1'b0, bus.cmd_len} + 17'd1;
                            end
                            default: begin
                                state_q    <= RD_REQ;
                                ldm_ena_q  <= 1'b1;
                                ldm_addr_q <= bus.cmd_base[LDM_AW-1:0];
                            end
                        endcase
                    end
                end
                WR_CFG, WR_LDM: begin
                    if (beat_s) begin
                        if (state_q == WR_CFG) begin
                            cfg_we_q   <= 1'b1;
                            cfg_addr_q <= cfg_addr_d;
                            cfg_din_q  <= bus.s_data;
                        end else begin
                            ldm_ena_q  <= 1'b1;
                            ldm_wea_q  <= 1'b1;
                            ldm_addr_q <= ldm_addr_d;
                            ldm_din_q  <= bus.s_data[DW-1:0];
                        end
                        if (last_s) begin
                            state_q     <= IDLE;
                            s_ready_q   <= 1'b0;
                            busy_q      <= 1'b0;
                            cmd_ready_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 17'd1;
                            idx_q <= idx_inc_s;
                        end
                    end else begin
                        state_q <= state_q;
                    end
                end
                RUN: begin
                    if (last_s) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 17'd1;
                    end
                end
                RD_REQ: begin
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (LDM_douta_valid_in) begin
                        m_data_q  <= LDM_douta_in;
                        m_valid_q <= 1'b1;
                        state_q   <= RD_OUT;
                    end else begin
                        state_q <= RD_WAIT;
                    end
                end
                RD_OUT: begin
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        if (last_s) begin
                            state_q     <= IDLE;
                            busy_q      <= 1'b0;
                            cmd_ready_q <= 1'b1;
                        end else begin
                            cnt_q      <= cnt_q - 17'd1;
                            idx_q      <= idx_inc_s;
                            state_q    <= RD_REQ;
                            ldm_ena_q  <= 1'b1;
                            ldm_addr_q <= ldm_addr_nx_d;
                        end
                    end else begin
                        state_q <= RD_OUT;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    s_ready_q   <= 1'b0;
                    m_valid_q   <= 1'b0;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.s_ready   = s_ready_q;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_data    = m_data_q;
    assign busy          = busy_q;
    assign start_out     = start_q;
    assign CFG_addra_out = cfg_addr_q;
    assign CFG_dina_out  = cfg_din_q;
    assign CFG_ena_out   = cfg_we_q;
    assign CFG_wea_out   = cfg_we_q;
    assign CFG_incr_out  = incr_q;
    assign LDM_addra_out = ldm_addr_q;
    assign LDM_dina_out  = ldm_din_q;
    assign LDM_ena_out   = ldm_ena_q;
    assign LDM_wea_out   = ldm_wea_q;

endmodule
